// File: rtl/video_frame_arbiter.sv
// video_frame_arbiter: frame-granular round-robin arbiter sharing one video pipeline between two sources.
// Latency: 1 cycle to arbitrate, then SOF hunt; PASS forwarding is combinational (0 cycles).
// Backpressure: down_ready goes straight to the granted source; no internal storage.
// Optional feature macro: FRAME_ARB_HUNT_TIMEOUT_EN (gives up an SOF hunt after HUNT_LIMIT cycles).
// Ports: clk, rst (async active-low); s0_*/s1_* source streams (data/valid/tlast/tuser in, ready out);
//   down_* stream to the pipeline; grant (registered source index); frame_done/err_line/err_sof pulses.
module video_frame_arbiter #(
  parameter int D_WIDTH    = 8,
  parameter int X_SIZE     = 320,
  parameter int Y_SIZE     = 200,
  parameter int CNT_WIDTH  = 16,
  parameter int HUNT_LIMIT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] s0_data,
  input  logic               s0_valid,
  input  logic               s0_tlast,
  input  logic               s0_tuser,
  output logic               s0_ready,
  input  logic [D_WIDTH-1:0] s1_data,
  input  logic               s1_valid,
  input  logic               s1_tlast,
  input  logic               s1_tuser,
  output logic               s1_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  output logic               down_tlast,
  output logic               down_tuser,
  input  logic               down_ready,
  output logic               grant,
  output logic               frame_done,
  output logic               err_line,
  output logic               err_sof
);

  localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(X_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(Y_SIZE - 1);

  typedef enum logic [1:0] {IDLE, HUNT, PASS} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_grant, w_grant_nxt;
  logic                 r_prio, w_prio_nxt;
  logic [CNT_WIDTH-1:0] r_x_cnt, w_x_nxt;
  logic [CNT_WIDTH-1:0] r_y_cnt, w_y_nxt;
  logic                 r_frame_done, w_frame_done_nxt;
  logic                 r_err_line, w_err_line_nxt;
  logic                 r_err_sof, w_err_sof_nxt;

  logic [D_WIDTH-1:0]   w_g_data;
  logic                 w_g_valid, w_g_tlast, w_g_tuser;
  logic                 w_g_ready, w_down_valid, w_xfer;

`ifdef FRAME_ARB_HUNT_TIMEOUT_EN
  localparam int HUNT_W = $clog2(HUNT_LIMIT + 1);
  localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(HUNT_LIMIT - 1);
  logic [HUNT_W-1:0] r_hunt_cnt, w_hunt_nxt;
`else
  // HUNT_LIMIT only matters when the timeout is built in.
  logic w_unused_hunt;
  assign w_unused_hunt = (HUNT_LIMIT == 0);
`endif

  // Mux of the currently granted source.
  assign w_g_data  = r_grant ? s1_data  : s0_data;
  assign w_g_valid = r_grant ? s1_valid : s0_valid;
  assign w_g_tlast = r_grant ? s1_tlast : s0_tlast;
  assign w_g_tuser = r_grant ? s1_tuser : s0_tuser;
  assign w_xfer    = w_g_valid & down_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_prio_nxt       = r_prio;
    w_x_nxt          = r_x_cnt;
    w_y_nxt          = r_y_cnt;
    w_frame_done_nxt = 1'b0;
    w_err_line_nxt   = 1'b0;
    w_err_sof_nxt    = 1'b0;
    w_g_ready        = 1'b0;
    w_down_valid     = 1'b0;
`ifdef FRAME_ARB_HUNT_TIMEOUT_EN
    w_hunt_nxt       = r_hunt_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          // prio only breaks ties; a lone requester always wins.
          w_grant_nxt = (s0_valid && s1_valid) ? r_prio : s1_valid;
          w_state_nxt = HUNT;
`ifdef FRAME_ARB_HUNT_TIMEOUT_EN
          w_hunt_nxt  = '0;
`endif
        end
      end
      HUNT: begin
        // Drop pre-SOF beats; leave the SOF beat in place for PASS to forward.
        w_g_ready = ~w_g_tuser;
        if (w_g_valid && w_g_tuser) begin
          w_state_nxt = PASS;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end
`ifdef FRAME_ARB_HUNT_TIMEOUT_EN
        else if (r_hunt_cnt == HUNT_LAST) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = ~r_grant;
        end else begin
          w_hunt_nxt  = r_hunt_cnt + 1'b1;
        end
`endif
      end
      PASS: begin
        w_down_valid = w_g_valid;
        w_g_ready    = down_ready;
        if (w_xfer) begin
          w_err_line_nxt = w_g_tlast ? (r_x_cnt != X_LAST) : (r_x_cnt == X_LAST);
          if (w_g_tuser && ((r_x_cnt != '0) || (r_y_cnt != '0))) begin
            // Mid-frame SOF: treat it as the first beat of a new frame.
            w_err_sof_nxt = 1'b1;
            w_x_nxt       = w_g_tlast ? '0 : CNT_WIDTH'(1);
            w_y_nxt       = w_g_tlast ? CNT_WIDTH'(1) : '0;
          end else if (w_g_tlast) begin
            if (r_y_cnt == Y_LAST) begin
              w_frame_done_nxt = 1'b1;
              w_state_nxt      = IDLE;
              w_prio_nxt       = ~r_grant;
              w_x_nxt          = '0;
              w_y_nxt          = '0;
            end else begin
              w_x_nxt = '0;
              w_y_nxt = r_y_cnt + 1'b1;
            end
          end else begin
            w_x_nxt = r_x_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_prio       <= 1'b0;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_frame_done <= 1'b0;
      r_err_line   <= 1'b0;
      r_err_sof    <= 1'b0;
`ifdef FRAME_ARB_HUNT_TIMEOUT_EN
      r_hunt_cnt   <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_prio       <= w_prio_nxt;
      r_x_cnt      <= w_x_nxt;
      r_y_cnt      <= w_y_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_err_line   <= w_err_line_nxt;
      r_err_sof    <= w_err_sof_nxt;
`ifdef FRAME_ARB_HUNT_TIMEOUT_EN
      r_hunt_cnt   <= w_hunt_nxt;
`endif
    end
  end

  assign s0_ready   = w_g_ready & ~r_grant;
  assign s1_ready   = w_g_ready &  r_grant;
  assign down_valid = w_down_valid;
  assign down_data  = w_g_data;
  assign down_tlast = w_g_tlast;
  assign down_tuser = w_g_tuser;
  assign grant      = r_grant;
  assign frame_done = r_frame_done;
  assign err_line   = r_err_line;
  assign err_sof    = r_err_sof;

endmodule
